// File: rtl/sc_level_sequencer.sv
// Level/lives sequencer for the Frogger game core: owns the current level and lives,
// clears the progress counter between levels and after deaths, and flags finish/game-over.
module sc_level_sequencer #(
    parameter int LEVEL_WIDTH = 3,
    parameter int NUM_LEVELS  = 3,
    parameter int PROG_WIDTH  = 5,
    parameter int PROG_TARGET = 20,
    parameter int LIVES       = 3,
    parameter int LIVES_WIDTH = 2,
    parameter int DONE_HOLD   = 4
) (
    input  logic                   SC_LEVEL_SEQUENCER_CLOCK_50,
    input  logic                   SC_LEVEL_SEQUENCER_RESET_InHigh,
    input  logic                   SC_LEVEL_SEQUENCER_Start_In,
    input  logic                   SC_LEVEL_SEQUENCER_Death_In,
    input  logic [PROG_WIDTH-1:0]  SC_LEVEL_SEQUENCER_ProgressCount_In,
    output logic [LEVEL_WIDTH-1:0] SC_LEVEL_SEQUENCER_CurrentLevel_Out,
    output logic [LIVES_WIDTH-1:0] SC_LEVEL_SEQUENCER_Lives_Out,
    output logic                   SC_LEVEL_SEQUENCER_StartCount_Out,
    output logic                   SC_LEVEL_SEQUENCER_LevelFinished_Out,
    output logic                   SC_LEVEL_SEQUENCER_FinishedGame_OutLow,
    output logic                   SC_LEVEL_SEQUENCER_GameOver_Out,
    output logic [2:0]             debug_state
);

    localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAY     = 3'd1,
        S_RESPAWN  = 3'd2,
        S_DONE     = 3'd3,
        S_ENDGAME  = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    state_t                 state, state_next;
    logic [HOLD_W-1:0]      hold_cnt, hold_next;
    logic [LEVEL_WIDTH-1:0] level_next;
    logic [LIVES_WIDTH-1:0] lives_next;

    // Output bundle {start_count, level_finished, finished_game_n, game_over} for a state.
    function automatic logic [3:0] decode(input state_t s);
        case (s)
            S_IDLE:     decode = 4'b1010;
            S_PLAY:     decode = 4'b0010;
            S_RESPAWN:  decode = 4'b1010;
            S_DONE:     decode = 4'b1110;
            S_ENDGAME:  decode = 4'b1100;
            S_GAMEOVER: decode = 4'b1011;
            default:    decode = 4'b1010;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        level_next = SC_LEVEL_SEQUENCER_CurrentLevel_Out;
        lives_next = SC_LEVEL_SEQUENCER_Lives_Out;
        case (state)
            S_IDLE, S_ENDGAME, S_GAMEOVER: begin
                if (SC_LEVEL_SEQUENCER_Start_In) begin
                    state_next = S_PLAY;
                    level_next = LEVEL_WIDTH'(1);
                    lives_next = LIVES_WIDTH'(LIVES);
                end
            end
            S_PLAY: begin
                // Completion outranks a same-cycle death, so no life is lost then.
                if (SC_LEVEL_SEQUENCER_ProgressCount_In >= PROG_WIDTH'(PROG_TARGET)) begin
                    state_next = S_DONE;
                    hold_next  = '0;
                end else if (SC_LEVEL_SEQUENCER_Death_In) begin
                    if (SC_LEVEL_SEQUENCER_Lives_Out > LIVES_WIDTH'(1)) begin
                        state_next = S_RESPAWN;
                        lives_next = SC_LEVEL_SEQUENCER_Lives_Out - LIVES_WIDTH'(1);
                    end else begin
                        state_next = S_GAMEOVER;
                        lives_next = '0;
                    end
                end
            end
            S_RESPAWN: state_next = S_PLAY;
            S_DONE: begin
                if (hold_cnt == HOLD_W'(DONE_HOLD - 1)) begin
                    if (SC_LEVEL_SEQUENCER_CurrentLevel_Out == LEVEL_WIDTH'(NUM_LEVELS)) begin
                        state_next = S_ENDGAME;
                    end else begin
                        state_next = S_PLAY;
                        level_next = SC_LEVEL_SEQUENCER_CurrentLevel_Out + LEVEL_WIDTH'(1);
                    end
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge SC_LEVEL_SEQUENCER_CLOCK_50 or posedge SC_LEVEL_SEQUENCER_RESET_InHigh) begin
        if (SC_LEVEL_SEQUENCER_RESET_InHigh) begin
            state                                  <= S_IDLE;
            hold_cnt                               <= '0;
            SC_LEVEL_SEQUENCER_CurrentLevel_Out    <= '0;
            SC_LEVEL_SEQUENCER_Lives_Out           <= LIVES_WIDTH'(LIVES);
            SC_LEVEL_SEQUENCER_StartCount_Out      <= 1'b1;
            SC_LEVEL_SEQUENCER_LevelFinished_Out   <= 1'b0;
            SC_LEVEL_SEQUENCER_FinishedGame_OutLow <= 1'b1;
            SC_LEVEL_SEQUENCER_GameOver_Out        <= 1'b0;
        end else begin
            state                               <= state_next;
            hold_cnt                            <= hold_next;
            SC_LEVEL_SEQUENCER_CurrentLevel_Out <= level_next;
            SC_LEVEL_SEQUENCER_Lives_Out        <= lives_next;
            {SC_LEVEL_SEQUENCER_StartCount_Out,
             SC_LEVEL_SEQUENCER_LevelFinished_Out,
             SC_LEVEL_SEQUENCER_FinishedGame_OutLow,
             SC_LEVEL_SEQUENCER_GameOver_Out}   <= decode(state_next);
        end
    end

    assign debug_state = state;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Self-checking bench for sc_level_sequencer: directed scenarios followed by random play,
// compared cycle by cycle against a game-rule model.
module tb_sc_level_sequencer;

    localparam int LEVEL_WIDTH = 3;
    localparam int NUM_LEVELS  = 3;
    localparam int PROG_WIDTH  = 5;
    localparam int PROG_TARGET = 20;
    localparam int LIVES       = 3;
    localparam int LIVES_WIDTH = 2;
    localparam int DONE_HOLD   = 4;

    localparam int M_IDLE = 0, M_PLAY = 1, M_RESPAWN = 2, M_DONE = 3, M_ENDGAME = 4, M_GAMEOVER = 5;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic                   death = 1'b0;
    logic [PROG_WIDTH-1:0]  prog = '0;
    logic [LEVEL_WIDTH-1:0] level;
    logic [LIVES_WIDTH-1:0] lives;
    logic                   start_count, level_finished, finished_game_n, game_over;
    logic [2:0]             debug_state;

    int checks = 0;
    int failures = 0;

    // Model of the game rules
    int m_mode, m_level, m_lives, m_done_left;

    sc_level_sequencer #(
        .LEVEL_WIDTH(LEVEL_WIDTH), .NUM_LEVELS(NUM_LEVELS), .PROG_WIDTH(PROG_WIDTH),
        .PROG_TARGET(PROG_TARGET), .LIVES(LIVES), .LIVES_WIDTH(LIVES_WIDTH), .DONE_HOLD(DONE_HOLD)
    ) dut (
        .SC_LEVEL_SEQUENCER_CLOCK_50           (clk),
        .SC_LEVEL_SEQUENCER_RESET_InHigh       (rst),
        .SC_LEVEL_SEQUENCER_Start_In           (start),
        .SC_LEVEL_SEQUENCER_Death_In           (death),
        .SC_LEVEL_SEQUENCER_ProgressCount_In   (prog),
        .SC_LEVEL_SEQUENCER_CurrentLevel_Out   (level),
        .SC_LEVEL_SEQUENCER_Lives_Out          (lives),
        .SC_LEVEL_SEQUENCER_StartCount_Out     (start_count),
        .SC_LEVEL_SEQUENCER_LevelFinished_Out  (level_finished),
        .SC_LEVEL_SEQUENCER_FinishedGame_OutLow(finished_game_n),
        .SC_LEVEL_SEQUENCER_GameOver_Out       (game_over),
        .debug_state                           (debug_state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_level = 0;
        m_lives = LIVES;
        m_done_left = 0;
    endtask

    task automatic model_edge(input int s, input int d, input int p);
        case (m_mode)
            M_IDLE, M_ENDGAME, M_GAMEOVER:
                if (s != 0) begin
                    m_mode = M_PLAY;
                    m_level = 1;
                    m_lives = LIVES;
                end
            M_PLAY:
                if (p >= PROG_TARGET) begin
                    m_mode = M_DONE;
                    m_done_left = DONE_HOLD;
                end else if (d != 0) begin
                    m_lives = m_lives - 1;
                    m_mode = (m_lives == 0) ? M_GAMEOVER : M_RESPAWN;
                end
            M_RESPAWN: m_mode = M_PLAY;
            M_DONE: begin
                m_done_left = m_done_left - 1;
                if (m_done_left == 0) begin
                    if (m_level == NUM_LEVELS) m_mode = M_ENDGAME;
                    else begin
                        m_level = m_level + 1;
                        m_mode = M_PLAY;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"}, int'(level), m_level);
        check({tag, ".lives"}, int'(lives), m_lives);
        check({tag, ".start_count"}, int'(start_count), (m_mode != M_PLAY) ? 1 : 0);
        check({tag, ".level_finished"}, int'(level_finished),
              (m_mode == M_DONE || m_mode == M_ENDGAME) ? 1 : 0);
        check({tag, ".finished_game_n"}, int'(finished_game_n), (m_mode == M_ENDGAME) ? 0 : 1);
        check({tag, ".game_over"}, int'(game_over), (m_mode == M_GAMEOVER) ? 1 : 0);
    endtask

    // One clock: apply inputs, let the edge happen, advance the model, then compare.
    task automatic step(input string tag, input int s, input int d, input int p);
        start = (s != 0);
        death = (d != 0);
        prog = PROG_WIDTH'(p);
        @(posedge clk);
        model_edge(s, d, p);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset_hold");

        step("idle_wait", 0, 0, 0);
        step("t1_start", 1, 0, 0);
        check("t1_level_is_1", int'(level), 1);

        step("t2_complete", 0, 0, PROG_TARGET);
        for (int i = 0; i < DONE_HOLD; i++) step("t2_hold", 0, 1, 5);
        check("t2_level_is_2", int'(level), 2);

        step("t3_l2_complete", 0, 0, 31);
        for (int i = 0; i < DONE_HOLD; i++) step("t3_hold2", 1, 0, 0);
        step("t3_l3_play", 0, 0, 7);
        step("t3_l3_complete", 0, 0, PROG_TARGET);
        for (int i = 0; i < DONE_HOLD + 2; i++) step("t3_endgame", 0, 0, 0);
        check("t3_finished_game_n", int'(finished_game_n), 0);
        step("t3_restart", 1, 0, 0);

        step("t4_death1", 0, 1, 3);
        step("t4_respawn1", 0, 0, 0);
        step("t4_death2", 1, 1, 3);
        step("t4_respawn2", 0, 0, 0);
        step("t4_death3", 0, 1, 3);
        check("t4_game_over", int'(game_over), 1);
        step("t4_gameover_stay", 0, 1, PROG_TARGET);
        step("t4_restart", 1, 0, 0);

        step("t5_death1", 0, 1, 0);
        step("t5_respawn1", 0, 0, 0);
        step("t5_death2", 0, 1, 0);
        step("t5_respawn2", 0, 0, 0);
        step("t5_both", 0, 1, PROG_TARGET);
        check("t5_lives_kept", int'(lives), 1);
        step("t6_in_done", 0, 0, 0);

        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("t6_async_reset");
        @(posedge clk);
        #1;
        check_all("t6_reset_held");
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            int s, d, p;
            s = ($urandom_range(0, 7) == 0) ? 1 : 0;
            d = ($urandom_range(0, 5) == 0) ? 1 : 0;
            p = ($urandom_range(0, 9) == 0) ? $urandom_range(PROG_TARGET, 31)
                                            : $urandom_range(0, PROG_TARGET - 1);
            step("random", s, d, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
